// File: rtl/quant_pkg.sv
// Shared definitions for the INT18-to-INT4 quantization scheduler: FSM encoding,
// default geometry and lane widths, plus a bank select helper.
package quant_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_WAIT_BANK = 2'd2,
        ST_QUANT     = 2'd3
    } qs_state_t;

    localparam int VEC_DEPTH_DEF  = 64;
    localparam int ADDR_W_DEF     = 6;
    localparam int SF_TIMEOUT_DEF = 66;

    localparam int INT18_W = 18;
    localparam int INT4_W  = 4;
    localparam int LANES   = 16;

    // One-hot mask of a bank within the two-entry full-flag vector.
    function automatic logic [1:0] bank_onehot(input logic bank);
        return bank ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/quant_bank_tracker.sv
// Ping-pong bank bookkeeping: two "block complete" flags, the bank the quantizer
// writes next and the bank offered to the consumer.
module quant_bank_tracker
    import quant_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_full,
    input  logic       rel_req,
    output logic [1:0] bank_full,
    output logic       wr_bank,
    output logic       rd_bank,
    output logic       rd_valid
);

    logic [1:0] full_r;
    logic [1:0] full_nxt_s;
    logic       wr_r;
    logic       rd_r;
    logic       rel_ok_s;

    // Next flag value; a set and a clear always target different banks.
    always_comb begin
        full_nxt_s = full_r;
        rel_ok_s   = rel_req && full_r[rd_r];
        if (set_full) begin
            full_nxt_s = full_nxt_s | bank_onehot(wr_r);
        end else begin
            full_nxt_s = full_nxt_s;
        end
        if (rel_ok_s) begin
            full_nxt_s = full_nxt_s & ~bank_onehot(rd_r);
        end else begin
            full_nxt_s = full_nxt_s;
        end
    end

    // Flag and pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_r <= 2'b00;
            wr_r   <= 1'b0;
            rd_r   <= 1'b0;
        end else begin
            full_r <= full_nxt_s;
            if (set_full) begin
                wr_r <= ~wr_r;
            end
            if (rel_ok_s) begin
                rd_r <= ~rd_r;
            end
        end
    end

    assign bank_full = full_r;
    assign wr_bank   = wr_r;
    assign rd_bank   = rd_r;
    assign rd_valid  = full_r[rd_r];

endmodule

// File: rtl/quant_sched.sv
// Scheduler that fills a vector buffer with one quantization block, launches the
// quantizer into a free INT4 bank and watches for completion or timeout.
module quant_sched
    import quant_pkg::*;
#(
    parameter int VEC_DEPTH  = VEC_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int SF_TIMEOUT = SF_TIMEOUT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_vbuf_we,
    output logic [ADDR_W-1:0] o_vbuf_addr,
    output logic              o_q_data_valid,
    output logic              o_q_start,
    input  logic              i_sf_valid,
    output logic              o_wr_bank,
    output logic              o_sf_we,
    output logic [1:0]        o_bank_full,
    output logic              o_rd_bank,
    output logic              o_rd_valid,
    input  logic              i_rd_release,
    output logic              o_busy,
    output logic              o_err
);

    localparam int TMO_W = $clog2(SF_TIMEOUT + 1);

    qs_state_t         state_r;
    qs_state_t         state_nxt_s;
    logic [ADDR_W-1:0] beat_cnt_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic              q_start_r;
    logic              err_r;
    logic              busy_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              sf_we_s;
    logic              last_beat_s;
    logic              tmo_hit_s;
    logic              wr_full_s;
    logic [1:0]        bank_full_s;
    logic              wr_bank_s;
    logic              rd_bank_s;
    logic              rd_valid_s;

    assign last_beat_s = (beat_cnt_r == ADDR_W'(VEC_DEPTH - 1));
    assign wr_full_s   = bank_full_s[wr_bank_s];
    assign tmo_hit_s   = (state_r == ST_QUANT) && !i_sf_valid &&
                         (tmo_cnt_r == TMO_W'(SF_TIMEOUT - 1));

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_FILL: begin
                if (accept_s && last_beat_s) begin
                    if (wr_full_s) begin
                        state_nxt_s = ST_WAIT_BANK;
                    end else begin
                        state_nxt_s = ST_QUANT;
                    end
                end else if (accept_s) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_WAIT_BANK: begin
                if (!wr_full_s) begin
                    state_nxt_s = ST_QUANT;
                end else begin
                    state_nxt_s = ST_WAIT_BANK;
                end
            end
            ST_QUANT: begin
                if (sf_we_s || tmo_hit_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_QUANT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Combinational handshake and strobe decode; the scale-factor strobe is
    // suppressed while reset is asserted so a reset cycle never commits a block.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_FILL: in_ready_s = 1'b1;
            default:          in_ready_s = 1'b0;
        endcase
        accept_s = i_in_valid && in_ready_s;
        sf_we_s  = i_rst_n && (state_r == ST_QUANT) && i_sf_valid;
    end

    // Beat and timeout counters plus registered status outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            beat_cnt_r <= {ADDR_W{1'b0}};
            tmo_cnt_r  <= {TMO_W{1'b0}};
            q_start_r  <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                beat_cnt_r <= last_beat_s ? {ADDR_W{1'b0}} : beat_cnt_r + ADDR_W'(1);
            end
            if (state_r == ST_QUANT) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end else begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end
            q_start_r <= (state_nxt_s == ST_QUANT) && (state_r != ST_QUANT);
            if (tmo_hit_s) begin
                err_r <= 1'b1;
            end
            busy_r <= (state_nxt_s != ST_IDLE);
        end
    end

    quant_bank_tracker u_bank_tracker (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .set_full  (sf_we_s),
        .rel_req   (i_rd_release),
        .bank_full (bank_full_s),
        .wr_bank   (wr_bank_s),
        .rd_bank   (rd_bank_s),
        .rd_valid  (rd_valid_s)
    );

    assign o_in_ready     = in_ready_s;
    assign o_vbuf_we      = accept_s;
    assign o_vbuf_addr    = beat_cnt_r;
    assign o_q_data_valid = accept_s;
    assign o_q_start      = q_start_r;
    assign o_sf_we        = sf_we_s;
    assign o_wr_bank      = wr_bank_s;
    assign o_bank_full    = bank_full_s;
    assign o_rd_bank      = rd_bank_s;
    assign o_rd_valid     = rd_valid_s;
    assign o_busy         = busy_r;
    assign o_err          = err_r;

endmodule

// File: tb/tb_quant_sched.sv
// Self-checking bench for quant_sched: table of block-level runs plus hand-written
// corner sequences, with a write-address scoreboard fed by the stimulus.
module tb_quant_sched;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_in_valid = 1'b0;
    logic       i_sf_valid = 1'b0;
    logic       i_rd_release = 1'b0;
    logic       o_in_ready, o_vbuf_we, o_q_data_valid, o_q_start;
    logic       o_wr_bank, o_sf_we, o_rd_bank, o_rd_valid, o_busy, o_err;
    logic [5:0] o_vbuf_addr;
    logic [1:0] o_bank_full;

    quant_sched dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_in_valid     (i_in_valid),
        .o_in_ready     (o_in_ready),
        .o_vbuf_we      (o_vbuf_we),
        .o_vbuf_addr    (o_vbuf_addr),
        .o_q_data_valid (o_q_data_valid),
        .o_q_start      (o_q_start),
        .i_sf_valid     (i_sf_valid),
        .o_wr_bank      (o_wr_bank),
        .o_sf_we        (o_sf_we),
        .o_bank_full    (o_bank_full),
        .o_rd_bank      (o_rd_bank),
        .o_rd_valid     (o_rd_valid),
        .i_rd_release   (i_rd_release),
        .o_busy         (o_busy),
        .o_err          (o_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int nchk = 0;
    int nfail = 0;
    int qs_cnt = 0;
    int qs_cyc = 0;
    int sf_cnt = 0;
    int last_beat_cyc = 0;
    int exp_addr_q[$];

    typedef struct {
        bit         rel;
        bit         hold;
        logic [1:0] full;
        logic       wr;
        logic       rd;
        logic       err;
    } row_t;
    row_t tbl[5];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard and event monitor, sampled mid-cycle
    always @(negedge i_clk) begin
        int e;
        if (i_rst_n) begin
            if (o_vbuf_we) begin
                if (exp_addr_q.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL vbuf_we_unexpected: got write at addr %0d required none", o_vbuf_addr);
                end else begin
                    e = exp_addr_q.pop_front();
                    chk("vbuf_addr", int'(o_vbuf_addr), e);
                    chk("q_data_valid", int'(o_q_data_valid), 1);
                    if (o_vbuf_addr == 6'd63) last_beat_cyc = cyc;
                end
            end
            if (o_q_start) begin
                qs_cnt++;
                qs_cyc = cyc;
            end
            if (o_sf_we) sf_cnt++;
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_in_valid = 1'b0;
        i_sf_valid = 1'b0;
        i_rd_release = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
        exp_addr_q.delete();
    endtask

    task automatic send_block(input int n);
        for (int i = 0; i < n; i++) begin
            i_in_valid = 1'b1;
            exp_addr_q.push_back(i);
            step();
        end
        i_in_valid = 1'b0;
    endtask

    task automatic wait_qs(input int exp_cyc, input string name);
        int base;
        int k;
        base = qs_cnt;
        k = 0;
        while (qs_cnt == base && k < 20) begin
            @(negedge i_clk);
            #1;
            k++;
        end
        chk({name, "_count"}, qs_cnt - base, 1);
        chk({name, "_cycle"}, qs_cyc, exp_cyc);
    endtask

    // Entered mid-cycle of the o_q_start cycle; completes or withholds at +65.
    task automatic do_sf(input bit hold, input bit rel);
        int base;
        base = sf_cnt;
        repeat (65) step();
        if (!hold) begin
            i_sf_valid = 1'b1;
            i_rd_release = rel;
            @(negedge i_clk);
            #1;
            chk("sf_we_on_valid", int'(o_sf_we), 1);
            step();
            i_sf_valid = 1'b0;
            i_rd_release = 1'b0;
            chk("sf_we_count", sf_cnt - base, 1);
            chk("busy_after_sf", int'(o_busy), 0);
        end else begin
            chk("err_before_timeout", int'(o_err), 0);
            chk("busy_before_timeout", int'(o_busy), 1);
            step();
            chk("err_at_timeout", int'(o_err), 1);
            chk("busy_at_timeout", int'(o_busy), 0);
            chk("in_ready_at_timeout", int'(o_in_ready), 1);
            chk("sf_we_count_hold", sf_cnt - base, 0);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [1:0] full, input logic wr,
                             input logic rd, input logic err);
        chk({tag, "_bank_full"}, int'(o_bank_full), int'(full));
        chk({tag, "_wr_bank"}, int'(o_wr_bank), int'(wr));
        chk({tag, "_rd_bank"}, int'(o_rd_bank), int'(rd));
        chk({tag, "_err"}, int'(o_err), int'(err));
        chk({tag, "_rd_valid"}, int'(o_rd_valid), int'(full[rd]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rel_cyc;

        // rel, hold, full, wr, rd, err after each block
        tbl[0] = '{1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1};

        do_reset();
        chk_flags("reset", 2'b00, 1'b0, 1'b0, 1'b0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_q_start", int'(o_q_start), 0);
        chk("reset_in_ready", int'(o_in_ready), 1);
        chk("reset_sf_we", int'(o_sf_we), 0);

        for (int r = 0; r < 5; r++) begin
            if (tbl[r].rel) begin
                i_rd_release = 1'b1;
                step();
                i_rd_release = 1'b0;
            end
            send_block(64);
            wait_qs(last_beat_cyc + 1, "q_start");
            do_sf(tbl[r].hold, 1'b0);
            chk_flags($sformatf("row%0d", r), tbl[r].full, tbl[r].wr, tbl[r].rd, tbl[r].err);
        end

        // Stray completion and release in IDLE with no full banks
        do_reset();
        base = sf_cnt;
        i_sf_valid = 1'b1;
        i_rd_release = 1'b1;
        @(negedge i_clk);
        #1;
        chk("stray_sf_we", int'(o_sf_we), 0);
        step();
        i_sf_valid = 1'b0;
        i_rd_release = 1'b0;
        step();
        chk_flags("stray", 2'b00, 1'b0, 1'b0, 1'b0);
        chk("stray_sf_count", sf_cnt - base, 0);
        chk("stray_busy", int'(o_busy), 0);

        // Reset at beat 30 of a fill discards the partial block
        send_block(30);
        i_in_valid = 1'b1;
        i_rst_n = 1'b0;
        step();
        i_in_valid = 1'b0;
        i_rst_n = 1'b1;
        base = qs_cnt;
        chk("abort_busy", int'(o_busy), 0);
        send_block(64);
        wait_qs(last_beat_cyc + 1, "q_start_after_abort");
        chk("abort_q_start_total", qs_cnt - base, 1);
        do_sf(1'b0, 1'b0);
        chk_flags("abort", 2'b01, 1'b1, 1'b0, 1'b0);

        // Both banks full: third block stalls until a release
        send_block(64);
        wait_qs(last_beat_cyc + 1, "q_start_second");
        do_sf(1'b0, 1'b0);
        chk_flags("two_full", 2'b11, 1'b0, 1'b0, 1'b0);
        send_block(64);
        chk("wait_in_ready", int'(o_in_ready), 0);
        chk("wait_busy", int'(o_busy), 1);
        base = qs_cnt;
        i_in_valid = 1'b1;
        repeat (4) step();
        i_in_valid = 1'b0;
        chk("wait_no_q_start", qs_cnt - base, 0);
        rel_cyc = cyc;
        i_rd_release = 1'b1;
        step();
        i_rd_release = 1'b0;
        wait_qs(rel_cyc + 2, "q_start_after_release");
        chk("wait_wr_bank", int'(o_wr_bank), 0);
        do_sf(1'b0, 1'b0);
        chk_flags("after_wait", 2'b11, 1'b1, 1'b1, 1'b0);

        // Completion of bank 1 coincides with release of bank 0
        do_reset();
        send_block(64);
        wait_qs(last_beat_cyc + 1, "q_start_c1");
        do_sf(1'b0, 1'b0);
        send_block(64);
        wait_qs(last_beat_cyc + 1, "q_start_c2");
        do_sf(1'b0, 1'b1);
        chk_flags("collide", 2'b10, 1'b0, 1'b1, 1'b0);

        // Reset during QUANT with a completion pulse commits nothing
        send_block(64);
        wait_qs(last_beat_cyc + 1, "q_start_rstq");
        repeat (10) step();
        i_rst_n = 1'b0;
        i_sf_valid = 1'b1;
        @(negedge i_clk);
        #1;
        chk("rst_quant_sf_we", int'(o_sf_we), 0);
        step();
        i_rst_n = 1'b1;
        i_sf_valid = 1'b0;
        chk_flags("rst_quant", 2'b00, 1'b0, 1'b0, 1'b0);
        chk("rst_quant_busy", int'(o_busy), 0);

        chk("scoreboard_drained", exp_addr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
